ex_muldiv_stage: RTL

Execute stage of the pipelined MIPS core, sitting directly downstream of the ID/EX pipeline register and containing the EX/MEM pipeline register at its output. It selects ALU operands, performs ALU and shift operations, and computes the branch target. It also contains an iterative multiply/divide unit with HI/LO registers. The unit runs in the background and stalls the pipeline only when a dependent instruction reaches EX.

---
 rtl/ex_pkg.sv | 46 ++++
 rtl/ex_muldiv_stage_muldiv.sv | 128 ++++++++++++
 rtl/ex_muldiv_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: datapath width, funct codes,
// aluop encodings and the mul/div sequencer state.
package ex_pkg;

  localparam int XLEN = 32;

  // R-type funct codes (imm[5:0])
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // aluop encodings from decode
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  // mul/div operation select (equals funct[1:0] of the issuing instruction)
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_stage_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers. One result bit per
// cycle on unsigned magnitudes; signs are applied in a final fixup cycle.
//
// Handshake: start is sampled only while the unit is idle and ce=1; it is
// accepted on that edge and busy rises after it. busy stays high until the
// edge that writes HI/LO. The issuer must hold off dependent reads (and any
// new start) while busy is high; start while busy is ignored.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MD_ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output md_state_e       state
);

  localparam int CW = $clog2(MD_ITER + 1);

  md_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic              is_div_q;
  logic              neg_q;    // negate product / quotient
  logic              rneg_q;   // negate remainder (dividend sign)
  logic [XLEN-1:0]   acc_q;    // product high half / partial remainder
  logic [XLEN-1:0]   qr_q;     // multiplier shifting out / quotient shifting in
  logic [XLEN-1:0]   b_q;      // multiplicand / divisor magnitude
  logic [XLEN-1:0]   hi_q, lo_q;

  logic [XLEN-1:0]   acc_d, qr_d;
  logic              signed_op;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     add_sum, shifted;
  logic              no_borrow;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Operand magnitudes captured at issue; unsigned ops pass through
  always_comb begin
    signed_op = ~op[0];
    mag_a     = (signed_op && a[XLEN-1]) ? -a : a;
    mag_b     = (signed_op && b[XLEN-1]) ? -b : b;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    add_sum   = {1'b0, acc_q} + (qr_q[0] ? {1'b0, b_q} : '0);
    shifted   = {acc_q, qr_q[XLEN-1]};
    no_borrow = (shifted >= {1'b0, b_q});
    if (is_div_q) begin
      acc_d = no_borrow ? (shifted[XLEN-1:0] - b_q) : shifted[XLEN-1:0];
      qr_d  = {qr_q[XLEN-2:0], no_borrow};
    end else begin
      acc_d = add_sum[XLEN:1];
      qr_d  = {add_sum[0], qr_q[XLEN-1:1]};
    end
  end

  // Sign fixup of the finished magnitudes
  always_comb begin
    prod_fix = neg_q  ? -{acc_q, qr_q} : {acc_q, qr_q};
    quo_fix  = neg_q  ? -qr_q  : qr_q;
    rem_fix  = rneg_q ? -acc_q : acc_q;
  end

  // Sequencer IDLE -> RUN (MD_ITER cycles) -> FIX -> IDLE; ce freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      qr_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (ce) begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_q  <= MD_RUN;
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_q    <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
            rneg_q   <= signed_op & a[XLEN-1];
            acc_q    <= '0;
            qr_q     <= mag_a;
            b_q      <= mag_b;
          end
        end
        MD_RUN: begin
          acc_q <= acc_d;
          qr_q  <= qr_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(MD_ITER - 1)) state_q <= MD_FIX;
        end
        MD_FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*XLEN-1:XLEN];
            lo_q <= prod_fix[XLEN-1:0];
          end
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy  = (state_q != MD_IDLE);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign state = state_q;

endmodule

// File: rtl/ex_muldiv_stage.sv
// MIPS execute stage: operand select, ALU/shifter, branch target adder,
// background mul/div unit and the EX/MEM pipeline register.
module ex_muldiv_stage
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MD_ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] regdata_rs,
  input  logic [XLEN-1:0] regdata_rt,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic [1:0]      wb,
  input  logic [2:0]      m,
  input  logic            alusrc,
  input  logic            regdst,
  input  logic [1:0]      aluop,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] exmem_alu,
  output logic [XLEN-1:0] exmem_store,
  output logic [XLEN-1:0] exmem_target,
  output logic            exmem_zero,
  output logic [4:0]      exmem_dst,
  output logic [1:0]      exmem_wb,
  output logic [2:0]      exmem_m,
  output md_state_e       md_state
);

  logic [5:0]      funct;
  logic [4:0]      shamt;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            is_rtype, is_md_issue, md_dep, md_start, md_busy;
  logic [XLEN-1:0] md_hi, md_lo;

  logic [XLEN-1:0] alu_q, store_q, target_q;
  logic            zero_q;
  logic [4:0]      dst_q;
  logic [1:0]      wb_q;
  logic [2:0]      m_q;

  assign funct       = imm[5:0];
  assign shamt       = imm[10:6];
  assign op_b        = alusrc ? imm : regdata_rt;
  assign is_rtype    = (aluop == ALUOP_RTYPE);
  assign is_md_issue = is_rtype && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign md_dep      = is_rtype && (funct inside {F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU});

  // A HI/LO reader or a second mul/div waits in EX until the unit is idle
  assign stall    = md_busy & md_dep & ~flush;
  assign md_start = is_md_issue & ~flush & ~stall;

  muldiv_unit #(
    .XLEN    (XLEN),
    .MD_ITER (MD_ITER)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .start (md_start),
    .op    (funct[1:0]),
    .a     (regdata_rs),
    .b     (regdata_rt),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo),
    .state (md_state)
  );

  // ALU and shifter; unknown R-type functs produce zero
  always_comb begin
    alu_res = '0;
    case (aluop)
      ALUOP_SUB: alu_res = regdata_rs - op_b;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_res = regdata_rs + op_b;
          F_SUB, F_SUBU: alu_res = regdata_rs - op_b;
          F_AND:  alu_res = regdata_rs & op_b;
          F_OR:   alu_res = regdata_rs | op_b;
          F_XOR:  alu_res = regdata_rs ^ op_b;
          F_NOR:  alu_res = ~(regdata_rs | op_b);
          F_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(regdata_rs) < $signed(op_b))};
          F_SLTU: alu_res = {{(XLEN-1){1'b0}}, (regdata_rs < op_b)};
          F_SLL:  alu_res = regdata_rt << shamt;
          F_SRL:  alu_res = regdata_rt >> shamt;
          F_SRA:  alu_res = $signed(regdata_rt) >>> shamt;
          F_MFHI: alu_res = md_hi;
          F_MFLO: alu_res = md_lo;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = regdata_rs + op_b;
    endcase
  end

  // EX/MEM register; bubbles (flush, stall, mul/div issue) clear wb and m
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q    <= '0;
      store_q  <= '0;
      target_q <= '0;
      zero_q   <= 1'b0;
      dst_q    <= '0;
      wb_q     <= '0;
      m_q      <= '0;
    end else if (ce) begin
      alu_q    <= alu_res;
      store_q  <= regdata_rt;
      target_q <= pc + (imm << 2);
      zero_q   <= (alu_res == '0);
      dst_q    <= regdst ? rd : rt;
      wb_q     <= (flush | stall | is_md_issue) ? 2'b00  : wb;
      m_q      <= (flush | stall | is_md_issue) ? 3'b000 : m;
    end
  end

  assign exmem_alu    = alu_q;
  assign exmem_store  = store_q;
  assign exmem_target = target_q;
  assign exmem_zero   = zero_q;
  assign exmem_dst    = dst_q;
  assign exmem_wb     = wb_q;
  assign exmem_m      = m_q;

endmodule
